// File: rtl/skid_ctrl_gen_mc.sv
// Per-lane skid-select generator for SCU.memShare(): one NOSKID/SKID controller per lane applying rules 1-3, plus b2b overrun flags.
// Latency: one cycle from sampled inputs to skid/b2b outputs; skid_active_cnt_o is combinational on the registered skid bits.
// Backpressure: none; valid_i qualifies the inputs and all lane state holds while it is low; flush_i clears regardless of valid_i.
module skid_ctrl_gen_mc #(
  parameter int CH_NUM            = 4,
  parameter int MAX_ALLOC_SEQ_NUM = 2,
  localparam int CNT_W            = $clog2(CH_NUM + 1)
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic              pipeCycle_begin_i,
  input  logic [CH_NUM-1:0] isGtr_i,
  output logic [CH_NUM-1:0] isColAddr_skid_o,
  output logic [CH_NUM-1:0] b2b_evt_o,
  output logic [CH_NUM-1:0] b2b_sticky_o,
  output logic [CNT_W-1:0]  skid_active_cnt_o
);

  // Run counter only needs to reach MAX_ALLOC_SEQ_NUM: the overrun resets it.
  localparam int RUN_W = $clog2(MAX_ALLOC_SEQ_NUM + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_ALLOC_SEQ_NUM);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  // Elaboration-time parameter sanity: a zero-lane or zero-sequence build is meaningless.
  if (CH_NUM < 1) begin : gBadChNum
    $fatal(1, "skid_ctrl_gen_mc: CH_NUM must be >= 1");
  end
  if (MAX_ALLOC_SEQ_NUM < 1) begin : gBadMaxSeq
    $fatal(1, "skid_ctrl_gen_mc: MAX_ALLOC_SEQ_NUM must be >= 1");
  end

  typedef enum logic {
    NOSKID = 1'b0,
    SKID   = 1'b1
  } skidState_t;

  skidState_t             stateQ [CH_NUM];
  skidState_t             stateD [CH_NUM];
  logic [RUN_W-1:0]       runQ   [CH_NUM];
  logic [RUN_W-1:0]       runD   [CH_NUM];
  logic [CH_NUM-1:0]      evtQ;
  logic [CH_NUM-1:0]      evtD;
  logic [CH_NUM-1:0]      stickyQ;
  logic [CH_NUM-1:0]      stickyD;
  logic [CNT_W-1:0]       activeCnt;

  // State, run counters and flags: async clear on rst, otherwise load the next-state values.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH_NUM; c++) begin
        stateQ[c] <= NOSKID;
        runQ[c]   <= '0;
      end
      evtQ    <= '0;
      stickyQ <= '0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        stateQ[c] <= stateD[c];
        runQ[c]   <= runD[c];
      end
      evtQ    <= evtD;
      stickyQ <= stickyD;
    end
  end

  // Per-lane next state: flush first, then on valid cycles rule 2 beats rules 1/3, run counts consecutive isGtr.
  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      stateD[c]  = stateQ[c];
      runD[c]    = runQ[c];
      evtD[c]    = 1'b0;
      stickyD[c] = stickyQ[c];

      if (flush_i) begin
        stateD[c]  = NOSKID;
        runD[c]    = '0;
        stickyD[c] = 1'b0;
      end else if (valid_i) begin
        if (isGtr_i[c] && (runQ[c] == RUN_MAX)) begin
          // Overrun: too many back-to-back allocation sequences; drop out of skid and restart the run.
          stateD[c]  = NOSKID;
          runD[c]    = '0;
          evtD[c]    = 1'b1;
          stickyD[c] = 1'b1;
        end else begin
          if ((stateQ[c] == NOSKID) && isGtr_i[c]) begin
            stateD[c] = SKID;
          end else if ((stateQ[c] == SKID) && isGtr_i[c] && pipeCycle_begin_i) begin
            stateD[c] = NOSKID;
          end
          runD[c] = isGtr_i[c] ? (runQ[c] + RUN_ONE) : '0;
        end
      end
    end
  end

  // Skid select is the lane state bit itself, so it is registered with no extra stage.
  always_comb begin
    isColAddr_skid_o = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      isColAddr_skid_o[c] = (stateQ[c] == SKID);
    end
  end

  // Number of lanes currently skidding, taken straight from the registered selects.
  always_comb begin
    activeCnt = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      activeCnt = activeCnt + CNT_W'(isColAddr_skid_o[c]);
    end
  end

  assign b2b_evt_o         = evtQ;
  assign b2b_sticky_o      = stickyQ;
  assign skid_active_cnt_o = activeCnt;

endmodule

// File: tb/tb_skid_ctrl_gen_mc.sv
// Bench for skid_ctrl_gen_mc: directed vector table on a 4-lane/MAX=2 instance, hand sequences for async reset,
// and a randomised regression of an 8-lane/MAX=3 instance against a behavioural model.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled at the same point.
module tb_skid_ctrl_gen_mc;

  logic sysClk = 1'b0;
  logic rst    = 1'b1;
  always #5 sysClk = ~sysClk;

  // Directed instance: 4 lanes, MAX=2
  logic       aValid, aFlush, aPcb;
  logic [3:0] aGtr, aSkid, aEvt, aSticky;
  logic [2:0] aCnt;

  // Random instance: 8 lanes, MAX=3
  logic       bValid, bFlush, bPcb;
  logic [7:0] bGtr, bSkid, bEvt, bSticky;
  logic [3:0] bCnt;

  skid_ctrl_gen_mc #(.CH_NUM(4), .MAX_ALLOC_SEQ_NUM(2)) dutA (
    .sys_clk(sysClk), .rst(rst), .valid_i(aValid), .flush_i(aFlush),
    .pipeCycle_begin_i(aPcb), .isGtr_i(aGtr), .isColAddr_skid_o(aSkid),
    .b2b_evt_o(aEvt), .b2b_sticky_o(aSticky), .skid_active_cnt_o(aCnt));

  skid_ctrl_gen_mc #(.CH_NUM(8), .MAX_ALLOC_SEQ_NUM(3)) dutB (
    .sys_clk(sysClk), .rst(rst), .valid_i(bValid), .flush_i(bFlush),
    .pipeCycle_begin_i(bPcb), .isGtr_i(bGtr), .isColAddr_skid_o(bSkid),
    .b2b_evt_o(bEvt), .b2b_sticky_o(bSticky), .skid_active_cnt_o(bCnt));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sysClk);
    #1;
  endtask

  typedef struct {
    logic       v, f, p;
    logic [3:0] g;
    logic [3:0] skid, evt, sticky;
    int         cnt;
  } vec_t;

  function automatic vec_t mk(logic v, logic f, logic p, logic [3:0] g,
                              logic [3:0] s, logic [3:0] e, logic [3:0] st, int c);
    vec_t r;
    r.v = v; r.f = f; r.p = p; r.g = g;
    r.skid = s; r.evt = e; r.sticky = st; r.cnt = c;
    return r;
  endfunction

  task automatic checkA(input string nm, input logic [3:0] s, input logic [3:0] e,
                        input logic [3:0] st, input int c);
    chk({nm, " skid"},   32'(aSkid),   32'(s));
    chk({nm, " evt"},    32'(aEvt),    32'(e));
    chk({nm, " sticky"}, 32'(aSticky), 32'(st));
    chk({nm, " cnt"},    32'(aCnt),    32'(c));
  endtask

  vec_t tbl[23];

  // Behavioural model state for the random instance
  int mSkid[8], mRun[8], mSticky[8], mEvt[8];

  initial begin
    aValid = 0; aFlush = 0; aPcb = 0; aGtr = '0;
    bValid = 0; bFlush = 0; bPcb = 0; bGtr = '0;

    //            v  f  p  isGtr    skid     evt      sticky   cnt
    // rule 1 and hold
    tbl[0]  = mk(1, 0, 0, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 2);
    tbl[1]  = mk(1, 0, 0, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 2);
    tbl[2]  = mk(1, 0, 0, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 2);
    // rule 3 on lane 0, then isGtr without pipeCycle_begin keeps SKID
    tbl[3]  = mk(1, 0, 1, 4'b0001, 4'b0100, 4'b0000, 4'b0000, 1);
    tbl[4]  = mk(1, 0, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1);
    tbl[5]  = mk(1, 0, 0, 4'b0001, 4'b0101, 4'b0000, 4'b0000, 2);
    tbl[6]  = mk(1, 0, 0, 4'b0001, 4'b0101, 4'b0000, 4'b0000, 2);
    tbl[7]  = mk(1, 0, 0, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 2);
    // rule 2 on lane 2: skid 1,1,0,1 with one evt pulse
    tbl[8]  = mk(1, 0, 0, 4'b0100, 4'b0101, 4'b0000, 4'b0000, 2);
    tbl[9]  = mk(1, 0, 0, 4'b0100, 4'b0101, 4'b0000, 4'b0000, 2);
    tbl[10] = mk(1, 0, 0, 4'b0100, 4'b0001, 4'b0100, 4'b0100, 1);
    tbl[11] = mk(1, 0, 0, 4'b0100, 4'b0101, 4'b0000, 4'b0100, 2);
    tbl[12] = mk(1, 0, 0, 4'b0000, 4'b0101, 4'b0000, 4'b0100, 2);
    // valid gating on lane 1: invalid cycles (with pipeCycle_begin) freeze everything
    tbl[13] = mk(1, 0, 0, 4'b0010, 4'b0111, 4'b0000, 4'b0100, 3);
    tbl[14] = mk(1, 0, 0, 4'b0010, 4'b0111, 4'b0000, 4'b0100, 3);
    tbl[15] = mk(0, 0, 1, 4'b1111, 4'b0111, 4'b0000, 4'b0100, 3);
    tbl[16] = mk(0, 0, 1, 4'b1111, 4'b0111, 4'b0000, 4'b0100, 3);
    tbl[17] = mk(0, 0, 1, 4'b1111, 4'b0111, 4'b0000, 4'b0100, 3);
    tbl[18] = mk(1, 0, 0, 4'b0010, 4'b0101, 4'b0010, 4'b0110, 2);
    // sticky on lanes 0 and 3, then flush with valid low
    tbl[19] = mk(1, 0, 0, 4'b1001, 4'b1101, 4'b0000, 4'b0110, 3);
    tbl[20] = mk(1, 0, 0, 4'b1001, 4'b1101, 4'b0000, 4'b0110, 3);
    tbl[21] = mk(1, 0, 0, 4'b1001, 4'b0100, 4'b1001, 4'b1111, 1);
    tbl[22] = mk(0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);

    // Reset state
    step();
    step();
    checkA("reset", 4'b0000, 4'b0000, 4'b0000, 0);
    chk("reset B skid",   32'(bSkid),   32'h0);
    chk("reset B sticky", 32'(bSticky), 32'h0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 23; i++) begin
      aValid = tbl[i].v; aFlush = tbl[i].f; aPcb = tbl[i].p; aGtr = tbl[i].g;
      step();
      checkA($sformatf("row%0d", i), tbl[i].skid, tbl[i].evt, tbl[i].sticky, tbl[i].cnt);
    end

    // Rule 2 re-run on lane 2 with async reset asserted between edges
    aValid = 1; aFlush = 0; aPcb = 0; aGtr = 4'b0100;
    step(); checkA("rerun e1", 4'b0100, 4'b0000, 4'b0000, 1);
    step(); checkA("rerun e2", 4'b0100, 4'b0000, 4'b0000, 1);
    step(); checkA("rerun e3", 4'b0000, 4'b0100, 4'b0100, 0);
    step(); checkA("rerun e4", 4'b0100, 4'b0000, 4'b0100, 1);
    #2 rst = 1'b1;
    #1 checkA("async rst", 4'b0000, 4'b0000, 4'b0000, 0);
    step();
    rst = 1'b0;
    // Run counter must restart from 0: two more isGtr cycles must not overrun
    step(); checkA("post rst e1", 4'b0100, 4'b0000, 4'b0000, 1);
    step(); checkA("post rst e2", 4'b0100, 4'b0000, 4'b0000, 1);
    aValid = 0; aGtr = '0;

    // Randomised regression on the 8-lane instance
    for (int c = 0; c < 8; c++) begin
      mSkid[c] = 0; mRun[c] = 0; mSticky[c] = 0; mEvt[c] = 0;
    end
    for (int n = 0; n < 10000; n++) begin
      logic [7:0] expSkid, expEvt, expSticky;
      bValid = ($urandom_range(0, 99) < 80);
      bFlush = ($urandom_range(0, 99) < 2);
      bPcb   = ($urandom_range(0, 99) < 25);
      for (int c = 0; c < 8; c++) bGtr[c] = ($urandom_range(0, 99) < 70);
      step();
      // Model: lanes advance only on valid, unflushed cycles; a 4th consecutive isGtr overruns.
      for (int c = 0; c < 8; c++) begin
        mEvt[c] = 0;
        if (bFlush) begin
          mSkid[c] = 0; mRun[c] = 0; mSticky[c] = 0;
        end else if (bValid) begin
          if (bGtr[c] && mRun[c] == 3) begin
            mSkid[c] = 0; mRun[c] = 0; mEvt[c] = 1; mSticky[c] = 1;
          end else begin
            if (bGtr[c]) begin
              if (mSkid[c] == 0) mSkid[c] = 1;
              else if (bPcb) mSkid[c] = 0;
              mRun[c] = mRun[c] + 1;
            end else begin
              mRun[c] = 0;
            end
          end
        end
      end
      for (int c = 0; c < 8; c++) begin
        expSkid[c]   = (mSkid[c] != 0);
        expEvt[c]    = (mEvt[c] != 0);
        expSticky[c] = (mSticky[c] != 0);
      end
      chk($sformatf("rnd%0d skid", n),   32'(bSkid),   32'(expSkid));
      chk($sformatf("rnd%0d evt", n),    32'(bEvt),    32'(expEvt));
      chk($sformatf("rnd%0d sticky", n), 32'(bSticky), 32'(expSticky));
      chk($sformatf("rnd%0d cnt", n),    32'(bCnt),    32'($countones(expSkid)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
